// File: rtl/reaction_pkg.sv
// rtl/reaction_pkg.sv - shared state encoding and LED bar helpers for the reaction-timer round sequencer
package reaction_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LIGHTS,
    DELAY,
    MEASURE,
    DONE,
    FAULT
  } state_t;

  localparam int MAX_LEDS = 32;

  // Top-aligned so any bar width takes its pattern from the MSB end.
  localparam logic [MAX_LEDS-1:0] FAULT_PATTERN = 32'hAAAA_AAAA;

  function automatic logic [MAX_LEDS-1:0] bar_fill(input int unsigned led_cnt);
    logic [MAX_LEDS-1:0] ones;
    ones = '1;
    return ~(ones >> led_cnt);
  endfunction

endpackage

// File: rtl/reaction_sat_counter.sv
// rtl/reaction_sat_counter.sv - saturating counter with clear, increment and saturation flag
module reaction_sat_counter #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);

  assign sat = &cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/reaction_round_ctrl.sv
// rtl/reaction_round_ctrl.sv - reaction-timer round sequencer; define BEST_TIME_EN to add best_ms tracking
module reaction_round_ctrl
  import reaction_pkg::*;
#(
  parameter int N_LEDS     = 10,
  parameter int STEP_TICKS = 500,
  parameter int DELAY_W    = 7,
  parameter int RT_W       = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_ms,
  input  logic               trigger,
  input  logic               reaction,
  input  logic [DELAY_W-1:0] lfsr_val,
  output logic               en_lfsr,
  output logic [N_LEDS-1:0]  ledr,
  output logic [RT_W-1:0]    rt_ms,
  output logic               rt_valid,
  output logic               false_start,
  output logic               busy
`ifdef BEST_TIME_EN
  ,
  output logic [RT_W-1:0]    best_ms
`endif
);

  localparam int LED_CW = $clog2(N_LEDS + 1);
  localparam int STEP_W = $clog2(STEP_TICKS + 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_TICKS - 1);
  localparam logic [LED_CW-1:0] LED_LAST  = LED_CW'(N_LEDS - 1);

  state_t             state, state_n;
  logic               trigger_q, trig_armed, trig_rise;
  logic [DELAY_W-1:0] dly;
  logic [STEP_W-1:0]  step_cnt;
  logic [LED_CW-1:0]  led_cnt;
  logic [RT_W-1:0]    rt_cnt;
  logic               rt_sat;
  logic               start, meas_clr, meas_inc, capture;

  // A trigger still held from reset must be released before it can start a round.
  assign trig_rise = trigger & ~trigger_q & trig_armed;

  reaction_sat_counter #(.W(RT_W)) u_rt_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (meas_clr),
    .inc   (meas_inc),
    .cnt   (rt_cnt),
    .sat   (rt_sat)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    start    = 1'b0;
    meas_clr = 1'b0;
    meas_inc = 1'b0;
    capture  = 1'b0;
    case (state)
      IDLE, DONE, FAULT: begin
        if (trig_rise) begin
          state_n = LIGHTS;
          start   = 1'b1;
        end
      end
      LIGHTS: begin
        if (reaction) begin
          state_n = FAULT;
        end else if (tick_ms && step_cnt == STEP_LAST && led_cnt == LED_LAST) begin
          state_n = DELAY;
        end
      end
      DELAY: begin
        if (reaction) begin
          state_n = FAULT;
        end else if (dly == '0) begin
          state_n  = MEASURE;
          meas_clr = 1'b1;
        end
      end
      MEASURE: begin
        // A saturated counter already holds the timeout value, so both exits capture rt_cnt.
        if (reaction || rt_sat) begin
          state_n = DONE;
          capture = 1'b1;
        end else begin
          meas_inc = tick_ms;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trigger_q  <= 1'b0;
      trig_armed <= 1'b0;
      dly        <= '0;
      step_cnt   <= '0;
      led_cnt    <= '0;
      rt_ms      <= '0;
      rt_valid   <= 1'b0;
    end else begin
      trigger_q <= trigger;
      if (!trigger) begin
        trig_armed <= 1'b1;
      end
      rt_valid <= capture;
      if (capture) begin
        rt_ms <= rt_cnt;
      end
      if (start) begin
        dly      <= lfsr_val;
        step_cnt <= '0;
        led_cnt  <= '0;
      end else if (state == LIGHTS && tick_ms) begin
        if (step_cnt == STEP_LAST) begin
          step_cnt <= '0;
          led_cnt  <= led_cnt + 1'b1;
        end else begin
          step_cnt <= step_cnt + 1'b1;
        end
      end else if (state == DELAY && tick_ms && dly != '0) begin
        dly <= dly - 1'b1;
      end
    end
  end

  always_comb begin
    ledr        = '0;
    en_lfsr     = 1'b0;
    busy        = 1'b0;
    false_start = 1'b0;
    case (state)
      IDLE, DONE: en_lfsr = 1'b1;
      LIGHTS: begin
        busy = 1'b1;
        ledr = N_LEDS'(bar_fill(32'(led_cnt)) >> (MAX_LEDS - N_LEDS));
      end
      DELAY: begin
        busy = 1'b1;
        ledr = '1;
      end
      MEASURE: busy = 1'b1;
      FAULT: begin
        en_lfsr     = 1'b1;
        false_start = 1'b1;
        ledr        = N_LEDS'(FAULT_PATTERN >> (MAX_LEDS - N_LEDS));
      end
      default: ledr = '0;
    endcase
  end

`ifdef BEST_TIME_EN
  // A timeout result is all ones and can never be strictly below best_ms.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      best_ms <= '1;
    end else if (rt_valid && rt_ms < best_ms) begin
      best_ms <= rt_ms;
    end
  end
`endif

endmodule
